// File: rtl/ms_slot_scheduler.sv
// Round-robin scheduler sharing one registered master-slave output slot among
// NUM_REQ blocking-write requesters, alternating grant (section_a) and offer (section_b).
package ms_slot_scheduler_pkg;
    typedef enum logic {
        section_a = 1'b0,
        section_b = 1'b1
    } Phases;
endpackage

module ms_slot_scheduler
    import ms_slot_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_data,
    input  logic [NUM_REQ-1:0]                req_sync,
    output logic [NUM_REQ-1:0]                req_notify,
    output logic [DATA_W-1:0]                 s_out,
    output logic                              s_out_valid,
    input  logic                              s_out_ready,
    output logic [$clog2(NUM_REQ)-1:0]        grant_id,
    output Phases                             phase,
    output logic [CNT_W-1:0]                  xfer_count
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]   N_WIDE   = (ID_W + 1)'(NUM_REQ);

    // Handshake: a value transfers at a rising edge where s_out_valid and
    // s_out_ready are both 1; valid never drops and s_out never changes before that.

    Phases                    phase_next;
    logic [ID_W-1:0]          last_grant;
    logic [ID_W-1:0]          start_idx;
    logic [ID_W-1:0]          win_idx;
    logic [ID_W:0]            cand_wide;
    logic                     any_req;

    logic [DATA_W-1:0]        s_out_d;
    logic                     valid_d;
    logic [NUM_REQ-1:0]       notify_d;
    logic [ID_W-1:0]          grant_d;
    logic [ID_W-1:0]          last_d;
    logic [CNT_W-1:0]         cnt_d;

    // Circular first-set scan; the sum stays below 2*NUM_REQ so one subtract wraps it.
    always_comb begin
        start_idx = (last_grant == LAST_IDX) ? '0 : last_grant + 1'b1;
        win_idx   = '0;
        any_req   = 1'b0;
        cand_wide = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_wide = {1'b0, start_idx} + (ID_W + 1)'(i);
            if (cand_wide >= N_WIDE) begin
                cand_wide = cand_wide - N_WIDE;
            end
            if (!any_req && req_sync[cand_wide[ID_W-1:0]]) begin
                any_req = 1'b1;
                win_idx = cand_wide[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= section_a;
        end else begin
            phase <= phase_next;
        end
    end

    always_comb begin
        phase_next = phase;
        case (phase)
            section_a: if (any_req)     phase_next = section_b;
            section_b: if (s_out_ready) phase_next = section_a;
            default:                    phase_next = section_a;
        endcase
    end

    always_comb begin
        s_out_d  = s_out;
        valid_d  = s_out_valid;
        notify_d = '0;
        grant_d  = grant_id;
        last_d   = last_grant;
        cnt_d    = xfer_count;
        case (phase)
            section_a: begin
                if (any_req) begin
                    s_out_d  = req_data[win_idx];
                    valid_d  = 1'b1;
                    notify_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
                    grant_d  = win_idx;
                end
            end
            section_b: begin
                if (s_out_ready) begin
                    valid_d = 1'b0;
                    last_d  = grant_id;
                    cnt_d   = xfer_count + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // last_grant resets to the top index so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_out       <= '0;
            s_out_valid <= 1'b0;
            req_notify  <= '0;
            grant_id    <= '0;
            last_grant  <= LAST_IDX;
            xfer_count  <= '0;
        end else begin
            s_out       <= s_out_d;
            s_out_valid <= valid_d;
            req_notify  <= notify_d;
            grant_id    <= grant_d;
            last_grant  <= last_d;
            xfer_count  <= cnt_d;
        end
    end
endmodule

// File: doc/ms_slot_scheduler.md
# ms_slot_scheduler

Round-robin scheduler that shares one master-slave output slot (`s_out`) among `NUM_REQ` blocking-write requesters. It alternates between two phases, `section_a` (grant/capture) and `section_b` (offer/hold), mirroring the phase style of the generated master-slave modules. It sits between several producer modules and a single downstream consumer. Each granted value is presented with a valid/ready handshake and acknowledged to its source with a one-cycle notify.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `DATA_W`, default 32: data width; matches `integer` when 32.
- `CNT_W`, default 16: width of the transfer counter.

Ports:
- `clk`  in  1: single clock; all logic is on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `req_data`  in  `NUM_REQ`×`DATA_W`: per-requester write value.
- `req_sync`  in  `NUM_REQ`: per-requester write request, level-held until notified.
- `req_notify`  out  `NUM_REQ`: one-cycle acknowledge to the granted requester.
- `s_out`  out  `DATA_W`: slot value; holds the last granted value between transfers.
- `s_out_valid`  out  1: `s_out` carries an unconsumed value.
- `s_out_ready`  in  1: consumer accepts the value.
- `grant_id`  out  `$clog2(NUM_REQ)`: index of the current or last grant.
- `phase`  out  `Phases`: current phase, `section_a` or `section_b`.
- `xfer_count`  out  `CNT_W`: number of completed transfers, wraps.

## Operation
**Reset.** When `rst` is high at an edge, the next-cycle values are:
- `phase` = `section_a`; `s_out` = 0; `s_out_valid` = 0; `req_notify` = 0; `grant_id` = 0; `xfer_count` = 0.
- Internal `last_grant` = `NUM_REQ-1`, so index 0 has first priority.

**`section_a`.** Sample `req_sync`.
- If no bit is set: stay in `section_a`, with all outputs held and `req_notify` = 0.
- Otherwise the winner w is the first set index, scanning circularly from `last_grant+1` mod `NUM_REQ`. At the edge:
  - `s_out` ← `req_data[w]`; `s_out_valid` ← 1; `grant_id` ← w.
  - `req_notify[w]` ← 1 and all other notify bits ← 0.
  - `phase` ← `section_b`.

**`section_b`.**
- `req_notify` ← 0 at the first edge; it is therefore exactly one cycle wide.
- `req_sync` is ignored. `s_out` and `grant_id` are stable.
- When `s_out_ready` = 1 at an edge: `s_out_valid` ← 0; `last_grant` ← `grant_id`; `xfer_count` ← `xfer_count+1` (mod 2^`CNT_W`); `phase` ← `section_a`.
- Otherwise hold all state.

**Arithmetic.**
- The round-robin index wraps modulo `NUM_REQ`. This must be correct for non-power-of-2 `NUM_REQ`.
- `xfer_count` wraps from 2^`CNT_W`-1 to 0 silently.

**Requester rule.**
- A requester keeps `req_sync` high and `req_data` stable until it samples `req_notify` = 1.
- It must drop `req_sync` in the cycle after `req_notify`, unless it is issuing a new write.
- A still-high `req_sync` in the next `section_a` is treated as a new request.

**Boundary conditions.**
- All requesters asserted: grants rotate strictly 0,1,2,...; no requester is granted twice while another waits.
- Single requester continuously asserted: it is granted every transfer.
- `s_out_ready` high while in `section_a` with `s_out_valid` = 0: ignored.
- `rst` in `section_b`: the value is discarded. `s_out_valid` = 0 and `s_out` = 0 next cycle; no extra notify; the count is not incremented.
- `rst` coincident with a grant: reset wins; no notify is issued.

## Timing
- Request-to-valid latency: `req_sync` sampled at edge E puts `s_out_valid`, `s_out`, and `req_notify` high in cycle E+1.
- The minimum transfer period is 2 cycles per value: `section_a` then `section_b` with `s_out_ready` already high.
  - Sustained throughput is 1 value / 2 cycles.
  - `s_out_valid` is never high in two back-to-back transfers without a low cycle between them.
- Back-pressure: `s_out_valid` stays high and `s_out` stays stable indefinitely until `s_out_ready`.
- `req_notify` is issued at grant, not at consumption. The value is owned by the scheduler from E+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- **Reset values:** assert `rst` mid-`section_b` holding `s_out`=0x55 → next cycle `phase`=`section_a`, `s_out`=0, `s_out_valid`=0, `xfer_count`=0, `req_notify`=0.
- **Single request:** `req_sync[2]`=1, `req_data[2]`=7, `s_out_ready`=1 → cycle+1: `s_out`=7, `s_out_valid`=1, `req_notify`=4'b0100, `grant_id`=2; cycle+2: `s_out_valid`=0, `xfer_count`=1.
- **Fairness:** all four requesters held high with data 10,11,12,13, ready=1 → `s_out` sequence 10,11,12,13,10,... with one transfer every 2 cycles.
- **Back-pressure:** grant value 9, hold `s_out_ready`=0 for 5 cycles → `s_out`=9 and `s_out_valid`=1 stable for 5 cycles; `req_notify` pulse is 1 cycle; new requests are not granted until after ready.
- **Non-power-of-2 wrap:** `NUM_REQ`=3, requests 0 and 2 held → grants alternate 0,2,0,2; index 3 is never produced.
- **Counter wrap:** `CNT_W`=4, 17 transfers → `xfer_count` reads 1.
